seg7_display_driver: RTL

SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_display_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment driver: segment table,
// blank pattern, digit geometry and the blink phase type.
package seg7_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit0 = a ... bit6 = g; entry [n] is hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  function automatic logic [SEG_W-1:0] seg_lookup(input logic [DIGIT_W-1:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-digit to active-low seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  assign seg = seg_lookup(digit);

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit seven-segment driver with PWM dimming, frame-synchronous value
// commit, leading-zero blanking and blinking; all segment outputs registered.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int TICK_DIV     = 256,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [15:0]      value,
  input  logic [3:0]       brightness,
  input  logic             blank_lz,
  input  logic             blink_en,
  output logic [SEG_W-1:0] hex0,
  output logic [SEG_W-1:0] hex1,
  output logic [SEG_W-1:0] hex2,
  output logic [SEG_W-1:0] hex3,
  output logic             pending
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [3:0]       pwm_reg, pwm_next;
  logic [3:0]       bri_reg, bri_next;
  logic [FRM_W-1:0] frm_reg, frm_next;
  blink_phase_e     phase_reg, phase_next;
  logic [15:0]      disp_reg, disp_next;
  logic [15:0]      shadow_reg, shadow_next;
  logic             pending_reg, pending_next;

  logic tick;
  logic frame_end;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_raw;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_reg, hex_next;
  logic [NUM_DIGITS-1:0]            digit_zero;
  logic [NUM_DIGITS-1:0]            lead_zero;
  logic                             upper_zero;
  logic                             pwm_on;
  logic                             blink_off;

  // Timebase: prescaler -> PWM step counter -> frame boundary.
  always_comb begin
    tick      = (pre_reg == PRE_LAST);
    frame_end = tick && (pwm_reg == 4'hF);
    pre_next  = tick ? '0 : pre_reg + 1'b1;
    pwm_next  = tick ? pwm_reg + 4'd1 : pwm_reg;
    bri_next  = frame_end ? brightness : bri_reg;
  end

  // Blink phase state machine, advanced once per BLINK_FRAMES frames.
  always_comb begin
    frm_next   = frm_reg;
    phase_next = phase_reg;
    if (frame_end) begin
      if (frm_reg == FRM_LAST) begin
        frm_next   = '0;
        phase_next = (phase_reg == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frm_next = frm_reg + 1'b1;
      end
    end
  end

  // Value path: loads land in the shadow and are committed only on a frame
  // boundary so a digit never changes mid-frame; a load on the boundary
  // itself goes straight through.
  always_comb begin
    disp_next    = disp_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    if (load && frame_end) begin
      disp_next    = value;
      shadow_next  = value;
      pending_next = 1'b0;
    end else if (load) begin
      shadow_next  = value;
      pending_next = 1'b1;
    end else if (frame_end && pending_reg) begin
      disp_next    = shadow_reg;
      pending_next = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [DIGIT_W-1:0] digit;
      assign digit          = disp_reg[gi*DIGIT_W +: DIGIT_W];
      assign digit_zero[gi] = (digit == '0);

      seg7_decode u_decode (
        .digit (digit),
        .seg   (seg_raw[gi])
      );
    end
  endgenerate

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & digit_zero[i];
      lead_zero[i] = upper_zero;
    end
  end

  always_comb begin
    pwm_on    = (bri_reg == 4'hF) || (pwm_reg < bri_reg);
    blink_off = blink_en && (phase_reg == PHASE_OFF);
    hex_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!pwm_on || blink_off || (blank_lz && lead_zero[i])) begin
        hex_next[i] = SEG_BLANK;
      end else begin
        hex_next[i] = seg_raw[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg     <= '0;
      pwm_reg     <= '0;
      bri_reg     <= '0;
      frm_reg     <= '0;
      phase_reg   <= PHASE_ON;
      disp_reg    <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_reg[i] <= SEG_BLANK;
      end
    end else begin
      pre_reg     <= pre_next;
      pwm_reg     <= pwm_next;
      bri_reg     <= bri_next;
      frm_reg     <= frm_next;
      phase_reg   <= phase_next;
      disp_reg    <= disp_next;
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
      hex_reg     <= hex_next;
    end
  end

  assign hex0    = hex_reg[0];
  assign hex1    = hex_reg[1];
  assign hex2    = hex_reg[2];
  assign hex3    = hex_reg[3];
  assign pending = pending_reg;

endmodule
